// File: rtl/cpu_types_pkg.sv
// Shared CPU types: data word and the load/store sequencer state encoding.
package cpu_types_pkg;

    typedef logic [31:0] word_t;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        FETCH  = 3'd1,
        DECODE = 3'd2,
        DATA   = 3'd3,
        DONE   = 3'd4,
        HALT   = 3'd5
    } lsu_state_t;

endpackage

// File: rtl/lsu_perf_counters.sv
// Free-running fetch / data / RAM-stall event counters for the load/store sequencer.
module lsu_perf_counters
    import cpu_types_pkg::*;
(
    input  logic        CLK,
    input  logic        nRST,
    input  lsu_state_t  state,
    input  logic        ramready,
    input  logic        dHit,
    input  logic        fetch_latch,
    output logic [31:0] fetch_cnt,
    output logic [31:0] data_cnt,
    output logic [31:0] stall_cnt
);

    word_t fetch_cnt_q, fetch_cnt_d;
    word_t data_cnt_q, data_cnt_d;
    word_t stall_cnt_q, stall_cnt_d;
    logic  stall;

    // HALT never produces any of these events, so the counters freeze there naturally.
    always_comb begin
        stall       = ((state == FETCH) || (state == DATA)) && !ramready;
        fetch_cnt_d = fetch_cnt_q + (fetch_latch ? 32'd1 : 32'd0);
        data_cnt_d  = data_cnt_q + (dHit ? 32'd1 : 32'd0);
        stall_cnt_d = stall_cnt_q + (stall ? 32'd1 : 32'd0);
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            fetch_cnt_q <= '0;
            data_cnt_q  <= '0;
            stall_cnt_q <= '0;
        end else begin
            fetch_cnt_q <= fetch_cnt_d;
            data_cnt_q  <= data_cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign fetch_cnt = fetch_cnt_q;
    assign data_cnt  = data_cnt_q;
    assign stall_cnt = stall_cnt_q;

endmodule

// File: rtl/lsu_mem_sequencer.sv
// Serialises instruction fetches and data loads/stores onto a single-port word RAM.
// Optional event counters are built when LSU_PERF_CNT_EN is defined.
//
// state  | meaning
// IDLE   | one cycle after reset
// FETCH  | instruction read from RAM at iaddr
// DECODE | datapath decodes iload; iHit here for non-memory instructions
// DATA   | data read or write at sdaddr
// DONE   | dHit pulse, sdload stable
// HALT   | datapath halted; no strobes until reset
module lsu_mem_sequencer
    import cpu_types_pkg::*;
(
    input  logic        CLK,
    input  logic        nRST,
    input  logic [31:0] iaddr,
    output logic [31:0] iload,
    output logic        iHit,
    input  logic        readReq,
    input  logic        writeReq,
    input  logic [31:0] sdaddr,
    input  logic [31:0] sdstore,
    output logic [31:0] sdload,
    output logic        dHit,
    input  logic        dhalt,
    input  logic        isVector,
    output logic        ramREN,
    output logic        ramWEN,
    output logic [31:0] ramaddr,
    output logic [31:0] ramstore,
    input  logic [31:0] ramload,
    input  logic        ramready
`ifdef LSU_PERF_CNT_EN
    ,
    output logic [31:0] fetch_cnt,
    output logic [31:0] data_cnt,
    output logic [31:0] stall_cnt
`endif
);

    lsu_state_t state_q, state_d;
    word_t      iload_q, iload_d;
    word_t      sdload_q, sdload_d;
    logic       is_write_q, is_write_d;
    logic       fetch_latch;

    always_comb begin
        state_d     = state_q;
        iload_d     = iload_q;
        sdload_d    = sdload_q;
        is_write_d  = is_write_q;
        fetch_latch = 1'b0;
        iHit        = 1'b0;
        dHit        = 1'b0;
        ramREN      = 1'b0;
        ramWEN      = 1'b0;
        ramaddr     = '0;
        ramstore    = '0;
        case (state_q)
            IDLE: state_d = FETCH;
            FETCH: begin
                ramaddr = iaddr;
                // Halt takes priority over a completing fetch; that word is dropped.
                if (dhalt) begin
                    state_d = HALT;
                end else begin
                    ramREN = 1'b1;
                    if (ramready) begin
                        iload_d     = ramload;
                        fetch_latch = 1'b1;
                        state_d     = DECODE;
                    end
                end
            end
            DECODE: begin
                if (writeReq) begin
                    is_write_d = 1'b1;
                    state_d    = DATA;
                end else if (readReq) begin
                    is_write_d = 1'b0;
                    state_d    = DATA;
                end else begin
                    iHit    = 1'b1;
                    state_d = FETCH;
                end
            end
            DATA: begin
                ramaddr = sdaddr;
                if (is_write_q) begin
                    ramWEN   = 1'b1;
                    ramstore = sdstore;
                end else begin
                    ramREN = 1'b1;
                end
                if (ramready) begin
                    if (!is_write_q) sdload_d = ramload;
                    state_d = DONE;
                end
            end
            DONE: begin
                dHit    = 1'b1;
                state_d = FETCH;
            end
            HALT: state_d = HALT;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q    <= IDLE;
            iload_q    <= '0;
            sdload_q   <= '0;
            is_write_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            iload_q    <= iload_d;
            sdload_q   <= sdload_d;
            is_write_q <= is_write_d;
        end
    end

    assign iload  = iload_q;
    assign sdload = sdload_q;

`ifdef LSU_PERF_CNT_EN
    logic unused_inputs;
    assign unused_inputs = isVector;

    lsu_perf_counters u_perf (
        .CLK         (CLK),
        .nRST        (nRST),
        .state       (state_q),
        .ramready    (ramready),
        .dHit        (dHit),
        .fetch_latch (fetch_latch),
        .fetch_cnt   (fetch_cnt),
        .data_cnt    (data_cnt),
        .stall_cnt   (stall_cnt)
    );
`else
    logic unused_inputs;
    assign unused_inputs = ^{isVector, fetch_latch};
`endif

endmodule

// File: tb/tb_lsu_mem_sequencer.sv
// Self-checking bench: per-instruction transaction model expanded into expected per-cycle outputs.
module tb_lsu_mem_sequencer;

    logic        CLK = 1'b0;
    logic        nRST = 1'b1;
    logic [31:0] iaddr, iload, sdaddr, sdstore, sdload, ramaddr, ramstore, ramload;
    logic        iHit, readReq, writeReq, dHit, dhalt, isVector, ramREN, ramWEN, ramready;
`ifdef LSU_PERF_CNT_EN
    logic [31:0] fetch_cnt, data_cnt, stall_cnt;
`endif

    always #5 CLK = ~CLK;

    lsu_mem_sequencer dut (
        .CLK      (CLK),
        .nRST     (nRST),
        .iaddr    (iaddr),
        .iload    (iload),
        .iHit     (iHit),
        .readReq  (readReq),
        .writeReq (writeReq),
        .sdaddr   (sdaddr),
        .sdstore  (sdstore),
        .sdload   (sdload),
        .dHit     (dHit),
        .dhalt    (dhalt),
        .isVector (isVector),
        .ramREN   (ramREN),
        .ramWEN   (ramWEN),
        .ramaddr  (ramaddr),
        .ramstore (ramstore),
        .ramload  (ramload),
        .ramready (ramready)
`ifdef LSU_PERF_CNT_EN
        ,
        .fetch_cnt (fetch_cnt),
        .data_cnt  (data_cnt),
        .stall_cnt (stall_cnt)
`endif
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    typedef struct {
        logic        ren, wen, ihit, dhit;
        logic [31:0] addr, store, il, sl;
        int          fc, dc, sc;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] m_iload = 0, m_sdload = 0;
    int          m_fetch = 0, m_data = 0, m_stall = 0;

    task automatic push(input logic ren, input logic wen, input logic ihit, input logic dhit,
                        input logic [31:0] addr, input logic [31:0] store);
        exp_t e;
        e.ren = ren; e.wen = wen; e.ihit = ihit; e.dhit = dhit;
        e.addr = addr; e.store = store; e.il = m_iload; e.sl = m_sdload;
        e.fc = m_fetch; e.dc = m_data; e.sc = m_stall;
        exp_q.push_back(e);
    endtask

    initial begin : compare
        exp_t e;
        forever begin
            @(negedge CLK);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("ramREN", ramREN, e.ren);
                check("ramWEN", ramWEN, e.wen);
                check("iHit", iHit, e.ihit);
                check("dHit", dHit, e.dhit);
                check("ramaddr", ramaddr, e.addr);
                check("ramstore", ramstore, e.store);
                check("iload", iload, e.il);
                check("sdload", sdload, e.sl);
`ifdef LSU_PERF_CNT_EN
                check("fetch_cnt", fetch_cnt, e.fc);
                check("data_cnt", data_cnt, e.dc);
                check("stall_cnt", stall_cnt, e.sc);
`endif
            end
        end
    end

    // Event log since the last reset release, used by the directed literal checks.
    int cyc, first_ren, ihit_cnt, ihit1, ihit2, dhit_cyc, ren_cnt, wen_cnt, wen_cyc;
    logic [31:0] dhit_sdload, wen_addr, wen_data;

    initial begin : monitor
        forever begin
            @(negedge CLK);
            if (!nRST) begin
                cyc = 0; first_ren = 0; ihit_cnt = 0; ihit1 = 0; ihit2 = 0;
                dhit_cyc = 0; ren_cnt = 0; wen_cnt = 0; wen_cyc = 0;
            end else begin
                cyc++;
                if (ramREN) begin
                    ren_cnt++;
                    if (first_ren == 0) first_ren = cyc;
                end
                if (iHit) begin
                    ihit_cnt++;
                    if (ihit_cnt == 1) ihit1 = cyc;
                    if (ihit_cnt == 2) ihit2 = cyc;
                end
                if (dHit) begin
                    dhit_cyc = cyc;
                    dhit_sdload = sdload;
                end
                if (ramWEN) begin
                    wen_cnt++;
                    wen_cyc = cyc;
                    wen_addr = ramaddr;
                    wen_data = ramstore;
                end
            end
        end
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic settle();
        @(negedge CLK);
        #1;
    endtask

    task automatic noise();
        readReq  = 1'($urandom_range(0, 1));
        writeReq = 1'($urandom_range(0, 1));
    endtask

    task automatic reset_seq(input bit expect_wen);
        settle();
        if (expect_wen) check("wen_before_rst", ramWEN, 1);
        nRST = 1'b0; dhalt = 1'b0; isVector = 1'b0; ramready = 1'b0;
        readReq = 1'b0; writeReq = 1'b0; ramload = 32'h0;
        #1;
        check("rst_ramREN", ramREN, 0);
        check("rst_ramWEN", ramWEN, 0);
        check("rst_iHit", iHit, 0);
        check("rst_dHit", dHit, 0);
        check("rst_ramaddr", ramaddr, 0);
        check("rst_ramstore", ramstore, 0);
        check("rst_iload", iload, 0);
        check("rst_sdload", sdload, 0);
`ifdef LSU_PERF_CNT_EN
        check("rst_fetch_cnt", fetch_cnt, 0);
        check("rst_data_cnt", data_cnt, 0);
        check("rst_stall_cnt", stall_cnt, 0);
`endif
        m_iload = 0; m_sdload = 0; m_fetch = 0; m_data = 0; m_stall = 0;
        repeat (2) @(posedge CLK);
        #1;
        nRST = 1'b1;
        push(0, 0, 0, 0, 0, 0);
    endtask

    // kind: 0 non-memory, 1 load, 2 store, 3 load+store request (store wins)
    task automatic run_instr(input int kind, input int wf, input int wd,
                             input logic [31:0] ia, input logic [31:0] iw,
                             input logic [31:0] da, input logic [31:0] ds,
                             input logic [31:0] rd, input int halt_at, input bit rst_data);
        iaddr = ia; sdaddr = da; sdstore = ds;
        for (int c = 0; c <= wf; c++) begin
            tick();
            noise();
            ramload = $urandom;
            if (c == halt_at) begin
                dhalt = 1'b1;
                ramready = 1'b0;
                push(0, 0, 0, 0, ia, 0);
                m_stall++;
                for (int h = 0; h < 20; h++) begin
                    tick();
                    noise();
                    ramready = 1'($urandom_range(0, 1));
                    ramload = $urandom;
                    push(0, 0, 0, 0, 0, 0);
                end
                return;
            end
            ramready = (c == wf);
            if (c == wf) ramload = iw;
            push(1, 0, 0, 0, ia, 0);
            if (c == wf) begin
                m_iload = iw;
                m_fetch++;
            end else begin
                m_stall++;
            end
        end
        tick();
        ramready = 1'($urandom_range(0, 1));
        ramload  = $urandom;
        readReq  = (kind == 1) || (kind == 3);
        writeReq = (kind >= 2);
        push(0, 0, kind == 0, 0, 0, 0);
        if (kind == 0) return;
        for (int c = 0; c <= wd; c++) begin
            tick();
            noise();
            ramready = (c == wd) && !rst_data;
            ramload  = (c == wd) ? rd : $urandom;
            push(kind == 1, kind != 1, 0, 0, da, (kind != 1) ? ds : 32'h0);
            if (rst_data) return;
            if (c == wd) begin
                if (kind == 1) m_sdload = rd;
            end else begin
                m_stall++;
            end
        end
        tick();
        noise();
        ramready = 1'($urandom_range(0, 1));
        ramload  = $urandom;
        push(0, 0, 0, 1, 0, 0);
        m_data++;
    endtask

    task automatic run_random(input int n);
        for (int i = 0; i < n; i++)
            run_instr($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
                      $urandom & 32'hFFFF_FFFC, $urandom, $urandom & 32'hFFFF_FFFC,
                      $urandom, $urandom, -1, 1'b0);
    endtask

    int c0, r0, w0, h0;

    initial begin
        iaddr = 0; sdaddr = 0; sdstore = 0; isVector = 0; dhalt = 0;
        readReq = 0; writeReq = 0; ramready = 0; ramload = 0;

        reset_seq(1'b0);
        run_instr(0, 0, 0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, -1, 1'b0);
        run_instr(0, 0, 0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, -1, 1'b0);
        settle();
        check("nop_first_ren_cycle", first_ren, 2);
        check("nop_first_ihit_cycle", ihit1, 3);
        check("nop_second_ihit_cycle", ihit2, 5);

        c0 = cyc; h0 = ihit_cnt;
        run_instr(1, 0, 2, 32'h4, 32'h8C01_0100, 32'h100, 32'h0, 32'hDEAD_BEEF, -1, 1'b0);
        settle();
        check("lw_dhit_cycle", dhit_cyc - c0, 6);
        check("lw_sdload", dhit_sdload, 32'hDEAD_BEEF);
        check("lw_no_ihit", ihit_cnt - h0, 0);

        w0 = wen_cnt;
        run_instr(2, 0, 0, 32'h8, 32'hAC01_0040, 32'h40, 32'h1234_5678, 32'h0, -1, 1'b0);
        settle();
        check("sw_wen_count", wen_cnt - w0, 1);
        check("sw_wen_addr", wen_addr, 32'h40);
        check("sw_wen_data", wen_data, 32'h1234_5678);
        check("sw_dhit_next", dhit_cyc - wen_cyc, 1);

        r0 = ren_cnt; w0 = wen_cnt;
        run_instr(3, 0, 0, 32'hC, 32'h1111_2222, 32'h80, 32'hCAFE_F00D, 32'h5555_AAAA, -1, 1'b0);
        settle();
        check("both_ren_fetch_only", ren_cnt - r0, 1);
        check("both_wen_count", wen_cnt - w0, 1);

        run_random(150);

        r0 = ren_cnt;
        run_instr(0, 3, 0, 32'h200, 32'h0, 32'h0, 32'h0, 32'h0, 1, 1'b0);
        settle();
        check("halt_ren_count", ren_cnt - r0, 1);
        reset_seq(1'b0);

        run_random(20);
        run_instr(2, 1, 2, 32'h300, $urandom, 32'h44, 32'h9999_8888, 32'h0, -1, 1'b1);
        reset_seq(1'b1);
        run_random(30);

        settle();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation exceeded time limit");
        errors++;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $fatal(1, "timeout");
    end

endmodule
